clock_divider: RTL and testbench

- Synthesizable integer clock divider. Derives a slow square-wave clock from the system clock, e.g. a 1 MHz tick clock from a 100 MHz board clock.
- Sits next to the top-level clocking logic and feeds low-rate peripherals (UART baud, LED or display scan).
- Output is a registered, glitch-free signal, fully synchronous to clk_i.

---
 rtl/clock_divider_if.sv | 13 +
 rtl/clock_divider.sv | 60 ++++++
 tb/tb_clock_divider.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/clock_divider_if.sv
// Output bundle of clock_divider: the divided clock, plus tick_o when CLOCK_DIV_TICK_EN is defined.
interface clock_divider_if;
    logic clk_o;
`ifdef CLOCK_DIV_TICK_EN
    logic tick_o;

    modport master (output clk_o, output tick_o);
    modport slave  (input  clk_o, input  tick_o);
`else
    modport master (output clk_o);
    modport slave  (input  clk_o);
`endif
endinterface

// File: rtl/clock_divider.sv
// Integer clock divider producing a registered square wave of period DIV clk_i cycles.
// Optional macro CLOCK_DIV_TICK_EN adds a one-cycle tick_o pulse on every rising edge of clk_o.
module clock_divider #(
    parameter real CLOCK_SYS = 100e6,
    parameter real CLOCK_OUT = 1e6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    clock_divider_if.master out_if
);

    localparam int DIV = $rtoi(CLOCK_SYS / CLOCK_OUT + 0.5);
    localparam int LOW = DIV / 2;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] LOW_M1 = CW'(LOW - 1);
    localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

    generate
        if (DIV < 2 || CLOCK_OUT > CLOCK_SYS) begin : g_bad_ratio
            $error("clock_divider: CLOCK_SYS/CLOCK_OUT must round to at least 2");
        end
    endgenerate

    logic [CW-1:0] cnt;
    logic          clk_q;

    // Wrap is an explicit compare to DIV-1 so non-power-of-2 ratios stay exact.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt   <= '0;
            clk_q <= 1'b0;
        end else begin
            cnt <= (cnt == DIV_M1) ? '0 : cnt + 1'b1;
            if (cnt == LOW_M1) begin
                clk_q <= 1'b1;
            end else if (cnt == DIV_M1) begin
                clk_q <= 1'b0;
            end
        end
    end

    assign out_if.clk_o = clk_q;

`ifdef CLOCK_DIV_TICK_EN
    logic tick_q;

    // Fires on the same edge that raises clk_q, so it lines up with its first high cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= (cnt == LOW_M1);
        end
    end

    assign out_if.tick_o = tick_q;
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Randomized self-checking bench for clock_divider at DIV=100, 5 and 2 against an edge-count model.
module tb_clock_divider;

    logic clk;
    logic rst;

    int compared   = 0;
    int mismatched = 0;

    // Non-reset rising edges seen since the last reset edge; the whole reference model hangs off this.
    int n_edges = 0;

    clock_divider_if if100 ();
    clock_divider_if if5 ();
    clock_divider_if if2 ();

    clock_divider #(.CLOCK_SYS(100e6), .CLOCK_OUT(1e6))  dut100 (.clk_i(clk), .rst_i(rst), .out_if(if100));
    clock_divider #(.CLOCK_SYS(100e6), .CLOCK_OUT(20e6)) dut5   (.clk_i(clk), .rst_i(rst), .out_if(if5));
    clock_divider #(.CLOCK_SYS(100e6), .CLOCK_OUT(50e6)) dut2   (.clk_i(clk), .rst_i(rst), .out_if(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) n_edges <= 0;
        else     n_edges <= n_edges + 1;
    end

    // Output is low for the first div/2 edges, then repeats HIGH high edges and LOW low edges.
    function automatic bit exp_clk(input int n, input int div);
        int low;
        low = div / 2;
        if (n < low) return 1'b0;
        return ((n - low) % div) < (div - low);
    endfunction

    function automatic bit exp_tick(input int n, input int div);
        int low;
        low = div / 2;
        if (n < low) return 1'b0;
        return ((n - low) % div) == 0;
    endfunction

    function automatic logic [2:0] exp_vec(input int n);
        return {exp_clk(n, 100), exp_clk(n, 5), exp_clk(n, 2)};
    endfunction

    task automatic test_reset();
        logic [2:0] obs;
        rst = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            obs = {if100.clk_o, if5.clk_o, if2.clk_o};
            compared++;
            if (obs !== 3'b000) begin
                mismatched++;
                $display("[TB] FAIL reset_hold cycle %0d: clk_o {100,5,2} got %b want 000", i, obs);
            end
`ifdef CLOCK_DIV_TICK_EN
            compared++;
            if (if100.tick_o !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL reset_tick cycle %0d: tick_o got %b want 0", i, if100.tick_o);
            end
`endif
        end
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        logic [2:0] obs;
        logic [2:0] want;
        logic       prev;
        int         rises;
        int         bad;
        prev  = 1'b0;
        rises = 0;
        bad   = 0;
        for (int i = 1; i <= 10000; i++) begin
            @(negedge clk);
            obs  = {if100.clk_o, if5.clk_o, if2.clk_o};
            want = exp_vec(n_edges);
            compared++;
            if (obs !== want) begin
                mismatched++;
                if (bad < 10) $display("[TB] FAIL free_run edge %0d: clk_o {100,5,2} got %b want %b", n_edges, obs, want);
                bad++;
            end
`ifdef CLOCK_DIV_TICK_EN
            compared++;
            if (if100.tick_o !== exp_tick(n_edges, 100)) begin
                mismatched++;
                if (bad < 10) $display("[TB] FAIL free_run_tick edge %0d: tick_o got %b want %b", n_edges, if100.tick_o, exp_tick(n_edges, 100));
                bad++;
            end
`endif
            if (if100.clk_o === 1'b1 && prev === 1'b0) rises++;
            prev = if100.clk_o;
        end
        compared++;
        if (rises !== 100) begin
            mismatched++;
            $display("[TB] FAIL period_count: rises in 100 us got %0d want 100", rises);
        end
    endtask

    task automatic test_mid_reset();
        int  wait_cnt;
        bit  seen;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (70) @(negedge clk);
        compared++;
        if (if100.clk_o !== exp_clk(70, 100)) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_pre: clk_o got %b want %b", if100.clk_o, exp_clk(70, 100));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        compared++;
        if (if100.clk_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_abort: clk_o got %b want 0", if100.clk_o);
        end
        wait_cnt = 0;
        seen     = 1'b0;
        while (!seen && wait_cnt < 200) begin
            @(negedge clk);
            wait_cnt++;
            if (if100.clk_o === 1'b1) seen = 1'b1;
        end
        compared++;
        if (!seen || wait_cnt !== 50) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_rise: edges to rise got %0d (seen=%0b) want 50", wait_cnt, seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] obs;
        logic [2:0] want;
        int         bad;
        bad = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            obs  = {if100.clk_o, if5.clk_o, if2.clk_o};
            want = exp_vec(n_edges);
            compared++;
            if (obs !== want) begin
                mismatched++;
                if (bad < 10) $display("[TB] FAIL random_reset cycle %0d edge %0d: clk_o {100,5,2} got %b want %b", i, n_edges, obs, want);
                bad++;
            end
`ifdef CLOCK_DIV_TICK_EN
            compared++;
            if (if100.tick_o !== exp_tick(n_edges, 100)) begin
                mismatched++;
                if (bad < 10) $display("[TB] FAIL random_tick cycle %0d: tick_o got %b want %b", i, if100.tick_o, exp_tick(n_edges, 100));
                bad++;
            end
`endif
            rst = ($urandom_range(0, 149) == 0) ? 1'b1 : (rst && ($urandom_range(0, 3) != 0));
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        $display("[TB] clock_divider bench start");
        test_reset();
        test_free_run();
        test_mid_reset();
        test_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
